// File: rtl/xgriscv_lsu.sv
// Load/store unit between the MEM stage and the byte-lane dmem.
// All outputs are registered; next-output values are computed alongside next-state.
module xgriscv_lsu #(
    parameter int XLEN = 32,
    parameter int AW   = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            dmem_we,
    output logic [3:0]      dmem_amp,
    output logic [AW-1:0]   dmem_ad,
    output logic [XLEN-1:0] dmem_wd,
    input  logic [XLEN-1:0] dmem_rd
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ST_SETUP,
        S_ST_WRITE,
        S_LD_READ,
        S_RESP,
        S_ERR_RESP
    } state_t;

    state_t          r_state, w_state_n;
    logic [2:0]      r_f3, w_f3_n;
    logic [1:0]      r_off, w_off_n;
    logic            r_ready, w_ready_n;
    logic            r_resp_valid, w_resp_valid_n;
    logic            r_err, w_err_n;
    logic [XLEN-1:0] r_rdata, w_rdata_n;
    logic            r_we, w_we_n;
    logic [3:0]      r_amp, w_amp_n;
    logic [AW-1:0]   r_ad, w_ad_n;
    logic [XLEN-1:0] r_wd, w_wd_n;

    logic            w_req_err;
    logic [3:0]      w_st_amp;
    logic [XLEN-1:0] w_st_wd;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load;

    always_comb begin
        w_req_err = 1'b0;
        if (|req_addr[XLEN-1:AW+2])
            w_req_err = 1'b1;
        if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111)
            w_req_err = 1'b1;
        if (req_we && req_funct3[2])
            w_req_err = 1'b1;
        if (req_funct3[1:0] == 2'b01 && req_addr[0])
            w_req_err = 1'b1;
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
            w_req_err = 1'b1;
    end

    always_comb begin
        case (req_funct3[1:0])
            2'b00: begin
                w_st_amp = 4'b0001 << req_addr[1:0];
                w_st_wd  = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_st_amp = req_addr[1] ? 4'b1100 : 4'b0011;
                w_st_wd  = {2{req_wdata[15:0]}};
            end
            default: begin
                w_st_amp = 4'b1111;
                w_st_wd  = req_wdata;
            end
        endcase
    end

    always_comb begin
        w_byte = dmem_rd[{r_off, 3'b000} +: 8];
        w_half = dmem_rd[{r_off[1], 4'b0000} +: 16];
        case (r_f3)
            3'b000:  w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b100:  w_load = {{(XLEN-8){1'b0}}, w_byte};
            3'b001:  w_load = {{(XLEN-16){w_half[15]}}, w_half};
            3'b101:  w_load = {{(XLEN-16){1'b0}}, w_half};
            default: w_load = dmem_rd;
        endcase
    end

    // Outputs are registered, so each branch sets the values for the state being entered.
    always_comb begin
        w_state_n      = r_state;
        w_f3_n         = r_f3;
        w_off_n        = r_off;
        w_ready_n      = 1'b0;
        w_resp_valid_n = 1'b0;
        w_err_n        = 1'b0;
        w_rdata_n      = '0;
        w_we_n         = 1'b0;
        w_amp_n        = '0;
        w_ad_n         = r_ad;
        w_wd_n         = r_wd;
        case (r_state)
            S_IDLE: begin
                w_ready_n = 1'b1;
                if (req_valid && r_ready) begin
                    w_ready_n = 1'b0;
                    w_f3_n    = req_funct3;
                    w_off_n   = req_addr[1:0];
                    if (w_req_err) begin
                        w_state_n      = S_ERR_RESP;
                        w_resp_valid_n = 1'b1;
                        w_err_n        = 1'b1;
                    end else if (req_we) begin
                        w_state_n = S_ST_SETUP;
                        w_ad_n    = req_addr[AW+1:2];
                        w_amp_n   = w_st_amp;
                        w_wd_n    = w_st_wd;
                    end else begin
                        w_state_n = S_LD_READ;
                        w_ad_n    = req_addr[AW+1:2];
                    end
                end
            end
            S_ST_SETUP: begin
                w_state_n = S_ST_WRITE;
                w_we_n    = 1'b1;
                w_amp_n   = r_amp;
            end
            S_ST_WRITE: begin
                w_state_n      = S_RESP;
                w_resp_valid_n = 1'b1;
            end
            S_LD_READ: begin
                w_state_n      = S_RESP;
                w_resp_valid_n = 1'b1;
                w_rdata_n      = w_load;
            end
            default: begin
                w_state_n = S_IDLE;
                w_ready_n = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_f3         <= '0;
            r_off        <= '0;
            r_ready      <= 1'b1;
            r_resp_valid <= 1'b0;
            r_err        <= 1'b0;
            r_rdata      <= '0;
            r_we         <= 1'b0;
            r_amp        <= '0;
            r_ad         <= '0;
            r_wd         <= '0;
        end else begin
            r_state      <= w_state_n;
            r_f3         <= w_f3_n;
            r_off        <= w_off_n;
            r_ready      <= w_ready_n;
            r_resp_valid <= w_resp_valid_n;
            r_err        <= w_err_n;
            r_rdata      <= w_rdata_n;
            r_we         <= w_we_n;
            r_amp        <= w_amp_n;
            r_ad         <= w_ad_n;
            r_wd         <= w_wd_n;
        end
    end

    assign req_ready  = r_ready;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_err;
    assign resp_rdata = r_rdata;
    assign dmem_we    = r_we;
    assign dmem_amp   = r_amp;
    assign dmem_ad    = r_ad;
    assign dmem_wd    = r_wd;

endmodule

// File: doc/xgriscv_lsu.md
Name: xgriscv_lsu

Overview:
- Load/store unit between the pipeline MEM stage and the byte-lane data memory (dmem).
- Accepts one load/store request at a time over a valid/ready handshake and checks alignment, range and funct3.
- For stores, generates the byte-lane mask and lane-replicated write data.
- For loads, extracts and sign/zero-extends the addressed byte, halfword or word from the raw memory word, then returns a single-cycle response.

Parameters:
- XLEN, 32, data and address width.
- AW, 7, dmem word-address width. Valid byte range is 0 to 2^(AW+2)-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- req_addr  input  XLEN  byte address.
- req_wdata  input  XLEN  store data (rs2).
- resp_valid  output  1  one-cycle response strobe; the consumer cannot stall it.
- resp_rdata  output  XLEN  extended load data; 0 for stores and errors.
- resp_err  output  1  request rejected (misaligned, out of range, or illegal funct3).
- dmem_we  output  1  dmem write enable.
- dmem_amp  output  4  dmem byte-lane mask; bit i selects bits [8i+7:8i].
- dmem_ad  output  AW  dmem word address, req_addr[AW+1:2].
- dmem_wd  output  XLEN  lane-replicated write data.
- dmem_rd  input  XLEN  dmem read word; combinational (asynchronous) read of dmem_ad.

Behaviour:
- Clocking and reset:
  - Single clock domain; reset is asynchronous and active-high.
  - All outputs are registered.
  - On reset: state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, dmem_we=0, dmem_amp=0, dmem_ad=0, dmem_wd=0.
- States and transitions:
  - IDLE:
    - req_ready=1. A request is accepted when req_valid&req_ready; address, funct3, we and wdata are latched.
    - Error request -> ERR_RESP.
    - Store -> ST_SETUP.
    - Load -> LD_READ.
  - ST_SETUP:
    - Drive dmem_ad, dmem_amp and dmem_wd; dmem_we=0.
    - dmem registers write data internally on this edge.
    - -> ST_WRITE.
  - ST_WRITE:
    - dmem_we=1 for exactly this one cycle; ad, amp and wd held unchanged from ST_SETUP.
    - -> RESP.
  - LD_READ:
    - Drive dmem_ad; dmem_amp=0, dmem_we=0.
    - At the end of the cycle, sample dmem_rd, extract and extend it, and register the result into resp_rdata.
    - -> RESP.
  - RESP:
    - resp_valid=1 for one cycle.
    - resp_rdata holds the load result, or 0 for a store.
    - -> IDLE.
  - ERR_RESP:
    - resp_valid=1 and resp_err=1 for one cycle; resp_rdata=0.
    - No dmem_we assertion and no dmem access.
    - -> IDLE.
- req_ready is 0 in every state except IDLE. Back-to-back requests are accepted in the cycle after RESP.
- Latency, counted from the acceptance edge T:
  - load: resp_valid at T+2.
  - store: dmem_we high at T+2, resp_valid at T+3.
  - error: resp_valid at T+1.
- Error conditions:
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]!=0.
  - Any addr[XLEN-1:AW+2]!=0.
  - funct3 011, 110 or 111.
  - Store with funct3[2]=1.
- Store lane rules, with o=addr[1:0]:
  - SB: amp=0001<<o; wd={4{wdata[7:0]}}.
  - SH: amp=(o[1]?1100:0011); wd={2{wdata[15:0]}}.
  - SW: amp=1111; wd=wdata.
- Load extract rules:
  - Byte: b=dmem_rd[8o+7:8o]. LB sign-extends b; LBU zero-extends b.
  - Halfword: h=dmem_rd[16o[1]+15:16o[1]]. LH sign-extends h; LHU zero-extends h.
  - LW returns dmem_rd unchanged.
- dmem_amp and dmem_we return to 0 in every state other than ST_SETUP/ST_WRITE.
- A reset asserted in any state forces IDLE immediately. If asserted during ST_WRITE, dmem_we drops asynchronously; the write may or may not have committed, and no response is produced.
- A request presented while req_ready=0 is ignored; the requester must hold it until it is accepted.

Test Plan:
- Reset then SW addr=0x10 wdata=0xDEADBEEF:
  - dmem_ad=4 and amp=1111 in ST_SETUP/ST_WRITE.
  - dmem_we high exactly 1 cycle at T+2.
  - resp_valid at T+3, resp_err=0.
  - Follow with LW 0x10 -> resp_rdata=0xDEADBEEF at T+2.
- SB addr=0x13 wdata=0x000000A5:
  - amp=1000, wd=0xA5A5A5A5.
  - Then LB 0x13 -> 0xFFFFFFA5.
  - Then LBU 0x13 -> 0x000000A5.
  - Then LW 0x10 -> 0xA5ADBEEF.
- SH addr=0x12 wdata=0x00008001:
  - amp=1100, wd=0x80018001.
  - Then LH 0x12 -> 0xFFFF8001; LHU 0x12 -> 0x00008001.
- Error requests: LW 0x11, SH 0x03, LB 0x200 (AW=7), funct3=011.
  - Each gives resp_valid+resp_err at T+1 and resp_rdata=0.
  - dmem_we never asserts.
  - A following LW 0x10 returns the unchanged word.
- Back-to-back and reset:
  - Hold req_valid high across 3 loads; each is accepted only when req_ready=1, with a 3-cycle spacing.
  - Assert reset during ST_SETUP of an SW to 0x20: dmem_we stays 0, outputs reach reset values immediately, and a later LW 0x20 returns the old data.
